// File: rtl/col2im_accum_pkg.sv
// col2im_accum_pkg: shared geometry defaults, derived sizes and the FSM state type
// for the col2im scatter-add accumulator.
package col2im_accum_pkg;

    localparam int unsigned C2I_IMG_H  = 28;
    localparam int unsigned C2I_IMG_W  = 28;
    localparam int unsigned C2I_K      = 3;
    localparam int unsigned C2I_DATA_W = 8;
    localparam int unsigned C2I_ACC_W  = 12;

    localparam int unsigned C2I_OUT_H    = C2I_IMG_H - C2I_K + 1;
    localparam int unsigned C2I_OUT_W    = C2I_IMG_W - C2I_K + 1;
    localparam int unsigned C2I_NUM_PIX  = C2I_IMG_H * C2I_IMG_W;
    localparam int unsigned C2I_NUM_ELEM = C2I_OUT_H * C2I_OUT_W * C2I_K * C2I_K;
    localparam int unsigned C2I_PIX_W    = $clog2(C2I_NUM_PIX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DRAIN = 2'd3
    } col2im_state_e;

    typedef logic [C2I_PIX_W-1:0] pix_idx_t;

endpackage

// File: rtl/col2im_accum_if.sv
// col2im_accum_if: control, column-input and pixel-output handshake bundle.
// master = producer/consumer environment, slave = the accumulator.
interface col2im_accum_if
    import col2im_accum_pkg::*;
#(
    parameter int unsigned DATA_W = C2I_DATA_W,
    parameter int unsigned ACC_W  = C2I_ACC_W
) ();
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic              busy;
    logic              done;

    modport master (
        output start, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, done
    );

    modport slave (
        input  start, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/col2im_accum_addr_gen.sv
// col2im_accum_addr_gen: k/l/m/n patch counter nest in im2col order (n innermost).
// Produces the scatter address (k+m)*IMG_W+(l+n) and flags the final element.
module col2im_accum_addr_gen
    import col2im_accum_pkg::*;
#(
    parameter int unsigned IMG_H = C2I_IMG_H,
    parameter int unsigned IMG_W = C2I_IMG_W,
    parameter int unsigned K     = C2I_K,
    parameter int unsigned PIX_W = C2I_PIX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_advance,
    output logic [PIX_W-1:0] o_addr,
    output logic             o_last
);
    localparam int unsigned OUT_H = IMG_H - K + 1;
    localparam int unsigned OUT_W = IMG_W - K + 1;
    localparam int unsigned N_W   = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned L_W   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int unsigned K_W   = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    logic [N_W-1:0]   r_n;
    logic [N_W-1:0]   r_m;
    logic [L_W-1:0]   r_l;
    logic [K_W-1:0]   r_k;
    logic             w_n_wrap;
    logic             w_m_wrap;
    logic             w_l_wrap;
    logic             w_k_wrap;
    logic [PIX_W-1:0] w_row;
    logic [PIX_W-1:0] w_col;

    assign w_n_wrap = (r_n == N_W'(K - 1));
    assign w_m_wrap = (r_m == N_W'(K - 1));
    assign w_l_wrap = (r_l == L_W'(OUT_W - 1));
    assign w_k_wrap = (r_k == K_W'(OUT_H - 1));

    assign w_row  = PIX_W'(r_k) + PIX_W'(r_m);
    assign w_col  = PIX_W'(r_l) + PIX_W'(r_n);
    assign o_addr = w_row * PIX_W'(IMG_W) + w_col;
    assign o_last = w_n_wrap & w_m_wrap & w_l_wrap & w_k_wrap;

    // Counter nest: each digit wraps to zero and carries into the next outer one.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_n <= '0;
            r_m <= '0;
            r_l <= '0;
            r_k <= '0;
        end else if (i_advance) begin
            if (w_n_wrap) begin
                r_n <= '0;
                if (w_m_wrap) begin
                    r_m <= '0;
                    if (w_l_wrap) begin
                        r_l <= '0;
                        r_k <= w_k_wrap ? '0 : r_k + K_W'(1);
                    end else begin
                        r_l <= r_l + L_W'(1);
                    end
                end else begin
                    r_m <= r_m + N_W'(1);
                end
            end else begin
                r_n <= r_n + N_W'(1);
            end
        end
    end

endmodule

// File: rtl/col2im_accum.sv
// col2im_accum: scatter-adds a stride-1 KxK im2col column stream into an
// IMG_H x IMG_W pixel buffer, then streams the pixels out row-major.
// Optional build macro: COL2IM_SATURATE_EN clamps each output pixel to the
// input range (2**DATA_W-1); accumulation itself always stays full width.
module col2im_accum
    import col2im_accum_pkg::*;
#(
    parameter int unsigned IMG_H  = C2I_IMG_H,
    parameter int unsigned IMG_W  = C2I_IMG_W,
    parameter int unsigned K      = C2I_K,
    parameter int unsigned DATA_W = C2I_DATA_W,
    parameter int unsigned ACC_W  = C2I_ACC_W
) (
    input  logic           clk,
    input  logic           reset,
    col2im_accum_if.slave  bus
);
    localparam int unsigned NUM_PIX = IMG_H * IMG_W;
    localparam int unsigned PIX_W   = $clog2(NUM_PIX);

    col2im_state_e    r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_data;
    logic             r_busy;
    logic             r_done;
    logic [PIX_W-1:0] r_pix;
    logic [ACC_W-1:0] r_buf [NUM_PIX];

    logic             w_accept;
    logic             w_last_elem;
    logic             w_last_pix;
    logic [PIX_W-1:0] w_addr;
    logic [PIX_W-1:0] w_pix_next;
    logic             w_clear;

    // Output view of an accumulated pixel (optionally clamped to the input range).
    function automatic logic [ACC_W-1:0] pix_value(input logic [ACC_W-1:0] v);
`ifdef COL2IM_SATURATE_EN
        logic [ACC_W-1:0] lim;
        lim = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};
        return (v > lim) ? lim : v;
`else
        return v;
`endif
    endfunction

    assign w_accept   = (r_state == ST_ACCUM) & r_in_ready & bus.in_valid;
    assign w_clear    = (r_state == ST_CLEAR);
    assign w_pix_next = r_pix + PIX_W'(1);
    assign w_last_pix = (r_pix == PIX_W'(NUM_PIX - 1));

    col2im_accum_addr_gen #(
        .IMG_H (IMG_H),
        .IMG_W (IMG_W),
        .K     (K),
        .PIX_W (PIX_W)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_clear),
        .i_advance (w_accept),
        .o_addr    (w_addr),
        .o_last    (w_last_elem)
    );

    // Pixel buffer: parallel clear on reset/CLEAR, read-modify-write on each accepted element.
    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            for (int i = 0; i < int'(NUM_PIX); i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_accept) begin
            r_buf[w_addr] <= r_buf[w_addr] + {{(ACC_W-DATA_W){1'b0}}, bus.in_data};
        end
    end

    // Control FSM with all handshake/status outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pix       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_state    <= ST_ACCUM;
                    r_in_ready <= 1'b1;
                end
                ST_ACCUM: begin
                    if (w_accept && w_last_elem) begin
                        r_state    <= ST_DRAIN;
                        r_in_ready <= 1'b0;
                        r_pix      <= '0;
                    end
                end
                ST_DRAIN: begin
                    // The last scatter write lands on the DRAIN entry edge, so the
                    // first read is taken one cycle later.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= pix_value(r_buf[r_pix]);
                    end else if (bus.out_ready) begin
                        if (w_last_pix) begin
                            r_out_valid <= 1'b0;
                            r_state     <= ST_IDLE;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_pix       <= '0;
                        end else begin
                            r_pix      <= w_pix_next;
                            r_out_data <= pix_value(r_buf[w_pix_next]);
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_col2im_accum.sv
// tb_col2im_accum: randomized scoreboard bench for col2im_accum. A reference
// scatter-add over a plain integer image produces the expected pixel queue; a
// separate monitor pops and compares on every output handshake.
module tb_col2im_accum;
    import col2im_accum_pkg::*;

    localparam int H  = 28;
    localparam int W  = 28;
    localparam int KK = 3;
    localparam int OH = H - KK + 1;
    localparam int OW = W - KK + 1;
    localparam int NP = H * W;
    localparam int NE = OH * OW * KK * KK;
    localparam int DW = 8;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    col2im_accum_if #(.DATA_W(DW), .ACC_W(AW)) bus ();

    col2im_accum #(
        .IMG_H(H), .IMG_W(W), .K(KK), .DATA_W(DW), .ACC_W(AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int cap[NP];
    int data_arr[NE];
    int hs_cnt;
    int done_cnt;
    bit mon_en;
    bit rdy_rand;
    bit prev_stall;
    int prev_data;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Reference: decode each element index into (k,l,m,n) and add into the image.
    task automatic model_push();
        int img[NP];
        int p, mn, k, l, m, n, v;
        for (int i = 0; i < NP; i++) img[i] = 0;
        for (int idx = 0; idx < NE; idx++) begin
            p  = idx / (KK * KK);
            mn = idx % (KK * KK);
            k  = p / OW;
            l  = p % OW;
            m  = mn / KK;
            n  = mn % KK;
            img[(k + m) * W + (l + n)] += data_arr[idx];
        end
        for (int i = 0; i < NP; i++) begin
            v = img[i];
`ifdef COL2IM_SATURATE_EN
            if (v > 255) v = 255;
`endif
            exp_q.push_back(v);
        end
    endtask

    // out_ready driver.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Monitor: scoreboard pops, hold-stability and in_ready legality.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("in_ready_only_in_accum",
                    int'(bus.in_ready & (bus.out_valid | ~bus.busy)), 0);
                if (prev_stall && bus.out_valid)
                    chk("out_data_stable", int'(bus.out_data), prev_data);
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = int'(bus.out_data);
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pixel", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pixel", int'(bus.out_data), e);
                    end
                    if (hs_cnt < NP) cap[hs_cnt] = int'(bus.out_data);
                    hs_cnt++;
                end
                if (bus.done) done_cnt++;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic do_start();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    // Feed 'limit' elements; optional random gaps and a start pulse mid-ACCUM.
    task automatic feed(input int limit, input bit gaps, input int glitch_at);
        int i   = 0;
        int cyc = 0;
        while (i < limit && cyc < 40000) begin
            @(posedge clk);
            #1;
            bus.start    = (glitch_at >= 0 && i == glitch_at);
            bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.in_data  = DW'(data_arr[i]);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) i++;
            cyc++;
        end
        if (i < limit) chk("feed_timeout", i, limit);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
    endtask

    task automatic finish_job(input bit glitch_drn);
        int cyc = 0;
        @(negedge clk);
        chk("in_ready_low_after_last", int'(bus.in_ready), 0);
        if (glitch_drn) begin
            while (hs_cnt < 100 && cyc < 5000) begin @(negedge clk); cyc++; end
            @(posedge clk); #1 bus.start = 1'b1;
            @(posedge clk); #1 bus.start = 1'b0;
        end
        cyc = 0;
        while ((hs_cnt < NP || done_cnt == 0) && cyc < 6000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (5) @(negedge clk);
        chk("handshakes", hs_cnt, NP);
        chk("done_pulses", done_cnt, 1);
        chk("busy_after_done", int'(bus.busy), 0);
        chk("out_valid_after_done", int'(bus.out_valid), 0);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    task automatic fill(input int pattern);
        for (int i = 0; i < NE; i++) begin
            case (pattern)
                0:       data_arr[i] = 1;
                1:       data_arr[i] = 255;
                2:       data_arr[i] = i % 256;
                default: data_arr[i] = int'($urandom_range(0, 255));
            endcase
        end
    endtask

    task automatic run_full(input int pattern, input bit gaps, input bit rdy,
                            input int glitch_acc, input bit glitch_drn);
        fill(pattern);
        hs_cnt   = 0;
        done_cnt = 0;
        rdy_rand = rdy;
        model_push();
        do_start();
        feed(NE, gaps, glitch_acc);
        finish_job(glitch_drn);
        rdy_rand = 1'b0;
    endtask

    task automatic check_ones();
        int sum = 0;
        for (int i = 0; i < NP; i++) sum += cap[i];
        chk("ones_pix_0_0", cap[0], 1);
        chk("ones_pix_0_1", cap[1], 2);
        chk("ones_pix_1_1", cap[W + 1], 4);
        chk("ones_pix_13_13", cap[13 * W + 13], 9);
        chk("ones_pix_27_27", cap[27 * W + 27], 1);
        chk("ones_sum", sum, NE);
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        mon_en        = 1'b0;
        rdy_rand      = 1'b0;
        prev_stall    = 1'b0;
        hs_cnt        = 0;
        done_cnt      = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        @(posedge clk); #1 reset = 1'b0;
        mon_en = 1'b1;

        // All ones, continuous input.
        run_full(0, 1'b0, 1'b0, -1, 1'b0);
        check_ones();

        // All 255.
        run_full(1, 1'b0, 1'b0, -1, 1'b0);
`ifdef COL2IM_SATURATE_EN
        chk("ff_pix_13_13", cap[13 * W + 13], 255);
`else
        chk("ff_pix_13_13", cap[13 * W + 13], 2295);
`endif
        chk("ff_pix_0_0", cap[0], 255);

        // index mod 256 with input gaps and stalled output, start pulsed in ACCUM and DRAIN.
        run_full(2, 1'b1, 1'b1, 1000, 1'b1);

        // Random data with gaps and random out_ready.
        run_full(3, 1'b1, 1'b1, -1, 1'b0);

        // Reset after 100 accepted elements, then a clean all-ones run.
        fill(0);
        hs_cnt   = 0;
        done_cnt = 0;
        do_start();
        feed(100, 1'b0, -1);
        reset  = 1'b1;
        mon_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_in_ready", int'(bus.in_ready), 0);
        chk("mid_rst_out_valid", int'(bus.out_valid), 0);
        chk("mid_rst_out_data", int'(bus.out_data), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_done", int'(bus.done), 0);
        @(posedge clk); #1 reset = 1'b0;
        mon_en = 1'b1;
        run_full(0, 1'b0, 1'b0, -1, 1'b0);
        check_ones();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
